// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx #(
    parameter int unsigned PRESCALE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       DATA_VALID,
    output logic       PAR_ERR,
    output logic       STOP_ERR
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] MID  = CW'(PRESCALE / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_reg_q, shift_reg_d;
    logic          par_acc_q, par_acc_d;
    logic          par_fail_q, par_fail_d;
    logic          stop_fail_q, stop_fail_d;
    logic          par_en_q, par_en_d;
    logic          par_typ_q, par_typ_d;
    logic [7:0]    p_data_q, p_data_d;
    logic          data_valid_q, data_valid_d;
    logic          par_err_q, par_err_d;
    logic          stop_err_q, stop_err_d;
    logic          decide;
    logic          sample;
    logic          last_edge;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] MID_M1 = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] MID_P1 = CW'(PRESCALE / 2 + 1);

    logic [1:0] vote_q, vote_d;

    // Early votes are captured at mid-1 and mid; the third is the live sample at mid+1.
    always_comb begin
        vote_d = vote_q;
        if (edge_cnt_q == MID_M1) vote_d[0] = rx_s_q;
        if (edge_cnt_q == MID)    vote_d[1] = rx_s_q;
        decide = (edge_cnt_q == MID_P1);
        sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) vote_q <= '1;
        else      vote_q <= vote_d;
    end
`else
    always_comb begin
        decide = (edge_cnt_q == MID);
        sample = rx_s_q;
    end
`endif

    assign last_edge = (edge_cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_reg_d  = shift_reg_q;
        par_acc_d    = par_acc_q;
        par_fail_d   = par_fail_q;
        stop_fail_d  = stop_fail_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;

        if (state_q != IDLE) edge_cnt_d = last_edge ? '0 : edge_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    // Detection cycle is edge 0 of the start bit.
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                    edge_cnt_d  = CW'(1);
                    bit_cnt_d   = '0;
                    par_acc_d   = 1'b0;
                    par_fail_d  = 1'b0;
                    stop_fail_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (decide && sample) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (last_edge) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_reg_d = {sample, shift_reg_q[7:1]};
                    par_acc_d   = par_acc_q ^ sample;
                end
                if (last_edge) begin
                    if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (decide && (sample != (par_acc_q ^ par_typ_q))) par_fail_d = 1'b1;
                if (last_edge) state_d = STOP;
            end
            STOP: begin
                if (decide && !sample) stop_fail_d = 1'b1;
                if (last_edge) begin
                    state_d = IDLE;
                    if (!par_fail_q && !stop_fail_d) begin
                        p_data_d     = shift_reg_q;
                        data_valid_d = 1'b1;
                    end else begin
                        par_err_d  = par_fail_q;
                        stop_err_d = stop_fail_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_reg_q  <= '0;
            par_acc_q    <= 1'b0;
            par_fail_q   <= 1'b0;
            stop_fail_q  <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_meta_q    <= RX_IN;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_reg_q  <= shift_reg_d;
            par_acc_q    <= par_acc_d;
            par_fail_q   <= par_fail_d;
            stop_fail_q  <= stop_fail_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STOP_ERR   = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and randomized frames against a
// frame-level reference model predicting each outcome pulse and its cycle.
module tb_uart_rx;

    localparam int unsigned P   = 8;
    localparam int unsigned MID = P / 2;

    typedef struct {
        int unsigned cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  pd;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STOP_ERR;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  last_good = 8'h00;
    ev_t         obs_q[$];
    ev_t         exp_q[$];

    uart_rx #(.PRESCALE(P)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STOP_ERR   (STOP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST && (DATA_VALID || PAR_ERR || STOP_ERR)) begin
            ev_t e;
            e.cyc = cyc;
            e.dv  = DATA_VALID;
            e.pe  = PAR_ERR;
            e.se  = STOP_ERR;
            e.pd  = P_DATA;
            obs_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input bit spike);
        RX_IN = b;
        if (!spike) begin
            wait_cyc(P);
        end else begin
            wait_cyc(MID);
            RX_IN = ~b;
            wait_cyc(1);
            RX_IN = b;
            wait_cyc(P - MID - 1);
        end
    endtask

    // Reference: the outcome appears N*P cycles after start detection, which
    // itself trails the RX_IN fall by the two synchronizer stages.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic par_bit, input logic stop_bit,
                              input int spike_idx, input bit scramble);
        ev_t         e;
        int unsigned t0;
        logic        par_ok;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        t0 = cyc;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (scramble && i == 2) begin
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            drive_bit(d[i], i == spike_idx);
        end
        if (pen) drive_bit(par_bit, 1'b0);
        drive_bit(stop_bit, 1'b0);
        RX_IN = 1'b1;

        par_ok = !pen || (par_bit == ((^d) ^ ptyp));
        e.cyc = t0 + (pen ? 11 : 10) * P + 2;
        if (par_ok && stop_bit) begin
            e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0; e.pd = d;
            last_good = d;
        end else begin
            e.dv = 1'b0; e.pe = !par_ok; e.se = !stop_bit; e.pd = last_good;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       pen, ptyp, good_par, stop_b;
        int unsigned n;

        wait_cyc(3);
        check("rst_p_data", P_DATA, 8'h00);
        check("rst_valid", DATA_VALID, 1'b0);
        check("rst_par_err", PAR_ERR, 1'b0);
        check("rst_stop_err", STOP_ERR, 1'b0);
        RST = 1'b1;
        wait_cyc(4);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_cyc(5);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_cyc(5);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        wait_cyc(5);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        wait_cyc(5);

        RX_IN = 1'b0;
        wait_cyc(3);
        RX_IN = 1'b1;
        wait_cyc(2 * P);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_cyc(5);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        wait_cyc(5);
`endif

        for (int k = 0; k < 24; k++) begin
            d        = 8'($urandom);
            pen      = 1'($urandom);
            ptyp     = 1'($urandom);
            good_par = (^d) ^ ptyp;
            stop_b   = ($urandom_range(7) != 0);
            send_frame(d, pen, ptyp, ($urandom_range(3) == 0) ? ~good_par : good_par,
                       stop_b, -1, 1'b1);
            wait_cyc($urandom_range(4));
        end
        wait_cyc(3 * P);

        // Reset in the middle of data bit 4 of a frame.
        check("pre_rst_p_data", P_DATA, last_good);
        PAR_EN = 1'b0;
        d = 8'hC3;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        RX_IN = d[4];
        wait_cyc(MID);
        RST = 1'b0;
        #1;
        check("mid_rst_p_data", P_DATA, 8'h00);
        check("mid_rst_valid", DATA_VALID, 1'b0);
        check("mid_rst_par_err", PAR_ERR, 1'b0);
        check("mid_rst_stop_err", STOP_ERR, 1'b0);
        last_good = 8'h00;
        RX_IN = 1'b1;
        wait_cyc(3);
        RST = 1'b1;
        wait_cyc(3);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_cyc(2 * P);

        check("event_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("ev%0d_cycle", i), obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("ev%0d_valid", i), obs_q[i].dv, exp_q[i].dv);
            check($sformatf("ev%0d_par_err", i), obs_q[i].pe, exp_q[i].pe);
            check($sformatf("ev%0d_stop_err", i), obs_q[i].se, exp_q[i].se);
            check($sformatf("ev%0d_p_data", i), obs_q[i].pd, exp_q[i].pd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver; the receive-side counterpart of the team's UART transmitter, sharing its frame format and parity configuration. It recovers frames (start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1) from the serial line RX_IN. Each received byte is presented on P_DATA with a one-cycle DATA_VALID pulse. It sits between the pad-side serial input and the system-side byte consumer.

## Interface
- PRESCALE, default 8: CLK cycles per bit. Even, 4..32; the counter width is derived from it.
- CLK  input  1  system clock, PRESCALE x baud rate.
- RST  input  1  reset, asynchronous, active-low.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  8  last good byte, registered.
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
- PAR_ERR  output  1  one-cycle pulse at the end of a frame with a parity mismatch.
- STOP_ERR  output  1  one-cycle pulse at the end of a frame whose stop bit sampled 0.

## Operation
- RX_IN passes through a 2-flop synchronizer (rx_s); all logic uses rx_s.
- Counters:
  - edge_cnt (0..PRESCALE-1) counts cycles within a bit.
  - bit_cnt (0..7) counts data bits.
- Sample point mid = PRESCALE/2. A bit's value is decided at the decision cycle (see Configuration).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s==0, latch PAR_EN/PAR_TYP for the frame, set edge_cnt<=1, go to START. The detection cycle counts as edge 0.
- START: at the decision cycle, if the sampled bit is 1 (false start), return to IDLE with no output pulses. Otherwise, at edge PRESCALE-1 go to DATA with bit_cnt=0.
- DATA: at each decision cycle, shift the sampled bit into shift_reg[7] (LSB first) and accumulate the parity XOR. At edge PRESCALE-1: if bit_cnt==7, go to PARITY if the latched PAR_EN is 1, else to STOP; otherwise bit_cnt++.
- PARITY: compare the sampled bit with XOR(data)^PAR_TYP; a mismatch sets par_fail. At edge PRESCALE-1 go to STOP.
- STOP: sampled bit 0 sets stop_fail. At edge PRESCALE-1 go to IDLE and register the outcome:
  - no failure: P_DATA<=shift_reg, DATA_VALID=1;
  - any failure: P_DATA holds its old value, DATA_VALID=0, PAR_ERR=par_fail, STOP_ERR=stop_fail (both may assert together).
- PAR_EN/PAR_TYP changes mid-frame are ignored until the next start detection.
- Back-to-back frames: the IDLE cycle after STOP is edge 0 of the next start bit, so zero-gap frames are received.
- Reset mid-frame: immediate return to IDLE; all counters, shift_reg and flags are cleared.

## Timing
- Reset values: P_DATA=8'h00, DATA_VALID=0, PAR_ERR=0, STOP_ERR=0; state IDLE; synchronizer flops =1.
- N = 10 bits (PAR_EN=0) or 11 bits (PAR_EN=1).
- Start detection (IDLE with rx_s==0) is cycle 0.
- DATA_VALID/PAR_ERR/STOP_ERR assert at cycle N*PRESCALE and last exactly one cycle.
- Latency from the RX_IN falling edge is N*PRESCALE+2 cycles, including the synchronizer.
- The outcome pulse cycle coincides with IDLE. Start detection in that cycle is legal and does not disturb the pulse.
- No back-pressure: the consumer must take P_DATA on the DATA_VALID cycle. P_DATA remains stable until the next good frame.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined:
  - each bit is sampled at edges mid-1, mid and mid+1, and the value is the 2-of-3 majority;
  - the decision cycle is mid+1;
  - a single-cycle glitch at the centre is rejected.
- Undefined: single sample at edge mid; the decision cycle is mid.
- Frame latency and pulse timing are identical in both builds.

## Test plan
- PRESCALE=8, PAR_EN=0, send 0xA5 -> single DATA_VALID pulse 82 cycles after the RX_IN fall, P_DATA=0xA5, PAR_ERR=STOP_ERR=0.
- PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> DATA_VALID, P_DATA=0x3C at cycle 90. Resend 0x3C with parity bit 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA stays 0x3C.
- PAR_EN=0, send 0x81 with stop bit 0 -> STOP_ERR pulse, no DATA_VALID.
- RX_IN low for 3 cycles then high -> false start, back to IDLE, no pulses. Then a valid 0x55 frame is received correctly.
- Zero-gap frames 0x55 then 0xAA -> two DATA_VALID pulses exactly 80 cycles apart with the correct bytes. With the macro defined, a 1-cycle inverted spike at the centre of data bit 3 still yields 0xAA.
- RST asserted during data bit 4 -> all outputs 0 immediately. After release, a full 0x0F frame yields DATA_VALID with P_DATA=0x0F.
